// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
// Ports: clk, reset (sync, active-high), start/op/a/b issue, busy, done, rd_data (MFHI/MFLO).
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;

  logic                 is_sgn, is_mul, is_div;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       div_t;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   prod, hl;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    is_sgn = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    unique case (1'b1)
      (op == OP_MULT),
      (op == OP_MADD),
      (op == OP_MSUB): begin
        is_sgn = 1'b1;
        is_mul = 1'b1;
      end
      (op == OP_MULTU),
      (op == OP_MADDU),
      (op == OP_MSUBU): is_mul = 1'b1;
      (op == OP_DIV): begin
        is_sgn = 1'b1;
        is_div = 1'b1;
      end
      (op == OP_DIVU): is_div = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = is_sgn & a[WIDTH-1];
  assign b_neg = is_sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Shift-add: p holds {partial, multiplier}; carry lands in the top bit.
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                 + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_nxt = {mul_sum, p_q[WIDTH-1:1]};

  // Restoring step: p holds {remainder, dividend}; partial rem < 2*divisor
  // so the difference always fits in WIDTH bits.
  assign div_t   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_ge  = div_t >= {1'b0, m_q};
  assign div_rem = div_t[WIDTH-1:0] - m_q;
  assign div_nxt = {div_ge ? div_rem : div_t[WIDTH-1:0],
                    p_q[WIDTH-2:0], div_ge};

  assign prod = neg_q ? -p_q : p_q;
  assign hl   = {hi_q, lo_q};
  assign quo  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    p_d     = p_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            op_d   = op;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            dz_d   = (b == '0);
            cnt_d  = CW'(WIDTH);
            if (is_mul) begin
              m_d     = a_mag;
              p_d     = {{WIDTH{1'b0}}, b_mag};
              state_d = S_MUL;
            end else begin
              m_d     = b_mag;
              p_d     = {{WIDTH{1'b0}}, a_mag};
              state_d = S_DIV;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_MUL: begin
        p_d   = mul_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        p_d   = div_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        unique case (1'b1)
          (op_q == OP_DIV),
          (op_q == OP_DIVU): begin
            // Divide by zero: quotient all ones, remainder recovers a.
            lo_d = dz_q ? '1 : quo;
            hi_d = rem;
          end
          (op_q == OP_MADD),
          (op_q == OP_MADDU): {hi_d, lo_d} = hl + prod;
          (op_q == OP_MSUB),
          (op_q == OP_MSUBU): {hi_d, lo_d} = hl - prod;
          default: {hi_d, lo_d} = prod;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIX);

  assign rd_data = (op == OP_MFHI) ? hi_q :
                   (op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed cases plus random ops
// checked against a plain-arithmetic HI/LO reference model.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] rd_data;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .rd_data(rd_data)
  );

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic         rd_chk = 1'b0;
  int           vecs = 0;
  int           errs = 0;
  int           done_cnt = 0;
  int           run = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  // Monitor: latency per done pulse, and queued rd_data expectations.
  always @(negedge clk) begin
    logic [W-1:0] e;
    string t;
    if (busy === 1'b1 && reset === 1'b0) run++;
    else run = 0;
    if (done === 1'b1) begin
      done_cnt++;
      vecs++;
      if (run != W + 1) begin
        errs++;
        $display("FAIL latency: busy cycles %0d at done, expected %0d", run, W + 1);
      end
    end
    if (rd_chk) begin
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL rd_data: got %h with no expected value queued", rd_data);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vecs++;
        if (rd_data !== e) begin
          errs++;
          $display("FAIL %s: rd_data=%h expected %h", t, rd_data, e);
        end
      end
    end
  end

  function automatic logic [63:0] ref_model(input logic [3:0] o,
      input logic [W-1:0] x, input logic [W-1:0] y, input logic [63:0] hl);
    logic [63:0] ps, pu;
    logic [31:0] q, r;
    int sq, sr;
    ps = {{32{x[31]}}, x} * {{32{y[31]}}, y};
    pu = {32'd0, x} * {32'd0, y};
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd5: return hl + ps;
      4'd6: return hl + pu;
      4'd7: return hl - ps;
      4'd8: return hl - pu;
      4'd3: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          return {32'd0, 32'h80000000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        q = sq;
        r = sr;
        return {r, q};
      end
      4'd4: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = x / y;
        r = x % y;
        return {r, q};
      end
      4'd9:  return {x, hl[31:0]};
      4'd10: return {hl[63:32], x};
      default: return hl;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", t, got, want);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    tick();
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 4'd0; a = '0; b = '0;
  endtask

  task automatic expect_rd(input logic [3:0] o, input logic [W-1:0] v, input string t);
    tick();
    op = o;
    exp_q.push_back(v);
    tag_q.push_back(t);
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
    op = 4'd0;
  endtask

  task automatic read_hilo(input string t);
    expect_rd(4'd11, m_hi, {t, " HI"});
    expect_rd(4'd12, m_lo, {t, " LO"});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      vecs++;
      errs++;
      $display("FAIL timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input string t);
    logic [63:0] r;
    int d0;
    r = ref_model(o, x, y, {m_hi, m_lo});
    d0 = done_cnt;
    issue(o, x, y);
    if (o >= 4'd1 && o <= 4'd8) begin
      wait_idle();
      chk({t, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    end
    m_hi = r[63:32];
    m_lo = r[31:0];
    read_hilo(t);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h80000000;
      2: return '1;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    logic [W-1:0] old_lo;
    int d0;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    read_hilo("reset");

    run_op(4'd1, 32'hFFFFFFFD, 32'd5, "MULT -3*5");
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "MULTU max*max");
    chk("MULTU HI const", 64'(m_hi), 64'hFFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, "DIV -7/2");
    chk("DIV -7/2 LO const", 64'(m_lo), 64'hFFFFFFFD);
    run_op(4'd4, 32'd7, 32'd0, "DIVU 7/0");
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "DIV MIN/-1");
    run_op(4'd3, 32'hFFFFFFF9, 32'd0, "DIV -7/0");
    run_op(4'd9, 32'd0, 32'd0, "MTHI 0");
    run_op(4'd10, 32'd10, 32'd0, "MTLO 10");
    run_op(4'd5, 32'd4, 32'd5, "MADD 4*5");
    run_op(4'd8, 32'd1, 32'd31, "MSUBU 1*31");

    // MTLO attempted while a divide is in flight must be dropped.
    old_lo = m_lo;
    r = ref_model(4'd3, 32'd100, 32'hFFFFFFF9, {m_hi, m_lo});
    d0 = done_cnt;
    issue(4'd3, 32'd100, 32'hFFFFFFF9);
    repeat (3) tick();
    start = 1'b1; op = 4'd10; a = 32'h1234;
    tick();
    start = 1'b0; op = 4'd12; a = '0;
    exp_q.push_back(old_lo);
    tag_q.push_back("busy MFLO old");
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0; op = 4'd0;
    chk("busy while div", 64'(busy), 64'd1);
    wait_idle();
    chk("div+MTLO done pulses", 64'(done_cnt - d0), 64'd1);
    m_hi = r[63:32];
    m_lo = r[31:0];
    read_hilo("DIV with ignored MTLO");

    // Reset in the middle of a multiply aborts with no commit.
    d0 = done_cnt;
    issue(4'd1, 32'd12345, 32'd678);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    chk("abort busy", 64'(busy), 64'd0);
    reset = 1'b0;
    chk("abort done pulses", 64'(done_cnt - d0), 64'd0);
    m_hi = '0;
    m_lo = '0;
    read_hilo("after abort");
    run_op(4'd1, 32'd12345, 32'hFFFFFD4A, "MULT after abort");

    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      run_op(o, rnd_val(), rnd_val(), $sformatf("rand%0d op%0d", i, o));
    end

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard: %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
- Owns the architectural HI/LO registers.
- Computes products and quotients bit-serially, one bit per cycle, and adds multiply-accumulate and multiply-subtract modes.
- Asserts busy while an operation is in flight so that hazard logic can stall MDU-dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO register width in bits (WIDTH >= 4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe; op/a/b are sampled on the rising edge when start=1 and the unit is idle.
- op  input  4  operation code:
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU
  - 9 MTHI, 10 MTLO, 11 MFHI, 12 MFLO
  - 13-15 NOP
- a  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- busy  output  1  high while an arithmetic operation is in flight.
- done  output  1  single-cycle pulse in the cycle HI/LO commit.
- rd_data  output  WIDTH  combinational read: HI when op=MFHI, LO when op=MFLO, else 0.

Behaviour:
- Reset:
  - HI=0, LO=0, state=IDLE, busy=0, done=0.
  - Any in-flight operation is aborted with no commit.
- FSM states: IDLE, MUL, DIV, FIX.
- In IDLE with start=1:
  - MULT/MULTU/MADD/MADDU/MSUB/MSUBU: latch operand magnitudes (absolute values for signed ops, raw values for unsigned) and the result sign; load bit counter = WIDTH; go to MUL.
  - DIV/DIVU: same latching; go to DIV.
  - MTHI: HI <= a. MTLO: LO <= a. Both take one cycle, stay IDLE, no busy, no done.
  - NOP/MFHI/MFLO: no state change.
- MUL: radix-2 shift-add over magnitudes; one multiplier bit per cycle; counter decrements. When the counter reaches 0, go to FIX.
- DIV: restoring division over magnitudes; one quotient bit per cycle; WIDTH cycles; then go to FIX.
- FIX (one cycle):
  - Apply sign correction.
  - Commit the 2*WIDTH-bit product as {HI,LO}: MULT/MULTU direct, MADD* as {HI,LO}+p, MSUB* as {HI,LO}-p. Arithmetic is modulo 2^(2*WIDTH).
  - Division commits LO = quotient, HI = remainder.
  - Assert done; return to IDLE.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Example: -7/2 gives LO=-3, HI=-1.
- Divide by zero (b=0), signed or unsigned: LO = all ones, HI = a. Full latency still applies.
- Signed overflow (MIN / -1): LO = MIN, HI = 0.
- Timing, for start sampled at edge t:
  - busy is high from after edge t through the FIX cycle, i.e. WIDTH+1 cycles.
  - done is high in the FIX cycle.
  - New HI/LO are visible after the edge that ends FIX.
  - Total latency is WIDTH+1 cycles for every arithmetic op.
- While busy:
  - start is ignored for all ops, including MTHI/MTLO; no queueing.
  - rd_data returns the committed (old) HI/LO values.
- busy is driven from registered state only, with no combinational path from start, so the hazard unit must OR busy with "arithmetic op starting this cycle".
- MADD/MSUB read HI/LO at FIX time, not at issue. Since HI/LO cannot change while busy, the two are equivalent.

Test Plan:
- Reset, then MULT with a=-3, b=5 (WIDTH=32) -> busy for exactly 33 cycles; done pulses once; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Follow with MFHI/MFLO reads -> rd_data matches.
- Divide cases:
  - DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
  - DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- MTHI 0, MTLO 10, then MADD a=4, b=5 -> {HI,LO}=30. Then MSUBU a=1, b=31 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- Issue DIV, then assert start with MTLO a=0x1234 on cycle 5 of busy -> ignored; LO holds the quotient afterwards; rd_data during busy shows the old LO.
- Issue MULT, assert reset on cycle 10 of busy -> next cycle busy=0, HI=LO=0, no done pulse; a new MULT afterwards completes normally.
